photon_wb_queue: RTL and testbench

//  Write-back source for the register file's photon write port (photon_regwrite /

---
 rtl/photon_wb_queue.sv | 120 ++++++++++++
 tb/tb_photon_wb_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/photon_wb_queue.sv
// photon_wb_queue: in-order write-back queue for photon coprocessor results
// headed for core integer registers. The head drains into the regfile photon
// port one entry per cycle. It yields to a same-register core MEM/WB write so
// that the photon value lands last. It also flags queued targets to decode.
module photon_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       Rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_rd,
    input  logic [31:0]                req_data,
    input  logic                       core_regwrite,
    input  logic [4:0]                 core_rd,
    input  logic                       mem_hold,
    output logic                       photon_regwrite,
    output logic [4:0]                 addr_corereg_photon,
    output logic [31:0]                photon_data_out,
    input  logic [4:0]                 chk_rs1,
    input  logic [4:0]                 chk_rs2,
    output logic                       pending_rs1,
    output logic                       pending_rs2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [4:0]       rd_mem_r   [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    logic             empty_s;
    logic             full_s;
    logic             core_wen_s;
    logic             collide_s;
    logic             push_s;
    logic             store_s;
    logic             pop_s;
    logic [4:0]       head_rd_s;
    logic [31:0]      head_data_s;
    logic             hit_rs1_s;
    logic             hit_rs2_s;

    // Head selection, collision detection and handshake decode; reset forces the empty view
    always_comb begin
        empty_s     = (count_r == CNT_W'(0));
        full_s      = (count_r == CNT_W'(DEPTH));
        head_rd_s   = empty_s ? 5'd0  : rd_mem_r[rd_ptr_r];
        head_data_s = empty_s ? 32'd0 : data_mem_r[rd_ptr_r];
        core_wen_s  = core_regwrite && (core_rd != 5'd0) && !mem_hold;
        // The core value must land first, so the photon head waits behind it
        collide_s   = core_wen_s && (core_rd == head_rd_s);
        pop_s       = !Rst && !empty_s && !collide_s;
        push_s      = !Rst && req_valid && !full_s;
        // Writes to x0 complete the handshake but never occupy an entry
        store_s     = push_s && (req_rd != 5'd0);

        req_ready           = Rst || !full_s;
        photon_regwrite     = pop_s;
        addr_corereg_photon = Rst ? 5'd0  : head_rd_s;
        photon_data_out     = Rst ? 32'd0 : head_data_s;
        count               = Rst ? CNT_W'(0) : count_r;
    end

    // Hazard scan across every stored entry, including the one retiring this cycle
    always_comb begin
        hit_rs1_s = 1'b0;
        hit_rs2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_rs1_s = hit_rs1_s | (valid_r[i] && (rd_mem_r[i] == chk_rs1));
            hit_rs2_s = hit_rs2_s | (valid_r[i] && (rd_mem_r[i] == chk_rs2));
        end
        pending_rs1 = !Rst && (chk_rs1 != 5'd0) && hit_rs1_s;
        pending_rs2 = !Rst && (chk_rs2 != 5'd0) && hit_rs2_s;
    end

    // FIFO storage, pointers and occupancy; reset discards everything queued
    always_ff @(posedge clk) begin
        if (Rst) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            valid_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else begin
            // Store and pop never touch the same slot: storing needs a free slot,
            // and popping needs a non-empty queue
            if (store_s) begin
                rd_mem_r[wr_ptr_r]   <= req_rd;
                data_mem_r[wr_ptr_r] <= req_data;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (store_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !store_s) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_photon_wb_queue.sv
// Directed bench for photon_wb_queue with a small regfile model fed by the photon port.
module tb_photon_wb_queue;

    logic        clk;
    logic        Rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_data;
    logic        core_regwrite;
    logic [4:0]  core_rd;
    logic        mem_hold;
    logic        photon_regwrite;
    logic [4:0]  addr_corereg_photon;
    logic [31:0] photon_data_out;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        pending_rs1;
    logic        pending_rs2;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [32] = '{default: 32'h0};

    photon_wb_queue #(.DEPTH(4)) dut (
        .clk                 (clk),
        .Rst                 (Rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_rd              (req_rd),
        .req_data            (req_data),
        .core_regwrite       (core_regwrite),
        .core_rd             (core_rd),
        .mem_hold            (mem_hold),
        .photon_regwrite     (photon_regwrite),
        .addr_corereg_photon (addr_corereg_photon),
        .photon_data_out     (photon_data_out),
        .chk_rs1             (chk_rs1),
        .chk_rs2             (chk_rs2),
        .pending_rs1         (pending_rs1),
        .pending_rs2         (pending_rs2),
        .count               (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: the photon port writes on the clock edge
    always @(posedge clk) begin
        if (photon_regwrite) rf[addr_corereg_photon] <= photon_data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; req_valid = 1'b0; req_rd = 5'd0; req_data = 32'd0;
        core_regwrite = 1'b0; core_rd = 5'd0; mem_hold = 1'b0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        tick(); tick();
        Rst = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
        checks++; if (photon_regwrite !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", photon_regwrite); end
        checks++; if (addr_corereg_photon !== 5'd0 || photon_data_out !== 32'd0) begin errors++; $display("FAIL reset_head: got %0d/%h want 0/0", addr_corereg_photon, photon_data_out); end
        checks++; if (pending_rs1 !== 1'b0 || pending_rs2 !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b%0b want 00", pending_rs1, pending_rs2); end
        tick();
    endtask

    task automatic test_single_push();
        req_valid = 1'b1; req_rd = 5'd5; req_data = 32'hDEADBEEF;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", req_ready); end
        checks++; if (photon_regwrite !== 1'b0) begin errors++; $display("FAIL single_same_cycle: got %0b want 0", photon_regwrite); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (photon_regwrite !== 1'b1) begin errors++; $display("FAIL single_strobe: got %0b want 1", photon_regwrite); end
        checks++; if (addr_corereg_photon !== 5'd5) begin errors++; $display("FAIL single_addr: got %0d want 5", addr_corereg_photon); end
        checks++; if (photon_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", photon_data_out); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf: got %h want deadbeef", rf[5]); end
    endtask

    task automatic test_full_blocked();
        core_regwrite = 1'b1; core_rd = 5'd10; mem_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_rd = 5'(10 + i); req_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        req_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", req_ready); end
        checks++; if (photon_regwrite !== 1'b0) begin errors++; $display("FAIL full_blocked: got %0b want 0", photon_regwrite); end
        req_valid = 1'b1; req_rd = 5'd14; req_data = 32'hBAD0_0014;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refuse: got %0d want 4", count); end
        core_regwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (photon_regwrite !== 1'b1 || addr_corereg_photon !== 5'(10 + i) || photon_data_out !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL drain_order%0d: got %0b/%0d/%h want 1/%0d/%h", i, photon_regwrite, addr_corereg_photon, photon_data_out, 10 + i, 32'hA000_0000 + 32'(i));
            end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
        checks++; if (rf[13] !== 32'hA000_0003 || rf[10] !== 32'hA000_0000) begin errors++; $display("FAIL drain_rf: got %h/%h want a0000000/a0000003", rf[10], rf[13]); end
        checks++; if (rf[14] !== 32'h0) begin errors++; $display("FAIL refused_rf: got %h want 0", rf[14]); end
    endtask

    task automatic test_collision();
        req_valid = 1'b1; req_rd = 5'd7; req_data = 32'h7777_0007;
        tick();
        req_valid = 1'b0; core_regwrite = 1'b1; core_rd = 5'd7; mem_hold = 1'b0;
        #1;
        checks++; if (photon_regwrite !== 1'b0) begin errors++; $display("FAIL collide_defer: got %0b want 0", photon_regwrite); end
        tick();
        core_regwrite = 1'b0;
        #1;
        checks++; if (photon_regwrite !== 1'b1 || addr_corereg_photon !== 5'd7) begin errors++; $display("FAIL collide_retry: got %0b/%0d want 1/7", photon_regwrite, addr_corereg_photon); end
        tick();
        checks++; if (rf[7] !== 32'h7777_0007) begin errors++; $display("FAIL collide_rf: got %h want 77770007", rf[7]); end
        req_valid = 1'b1; req_rd = 5'd7; req_data = 32'h8888_0008;
        tick();
        req_valid = 1'b0; core_regwrite = 1'b1; core_rd = 5'd7; mem_hold = 1'b1;
        #1;
        checks++; if (photon_regwrite !== 1'b1) begin errors++; $display("FAIL hold_no_defer: got %0b want 1", photon_regwrite); end
        tick();
        core_regwrite = 1'b0; mem_hold = 1'b0;
        checks++; if (rf[7] !== 32'h8888_0008 || count !== 3'd0) begin errors++; $display("FAIL hold_rf: got %h/%0d want 88880008/0", rf[7], count); end
        req_valid = 1'b1; req_rd = 5'd8; req_data = 32'h0000_0808;
        tick();
        req_valid = 1'b0; core_regwrite = 1'b1; core_rd = 5'd6;
        #1;
        checks++; if (photon_regwrite !== 1'b1) begin errors++; $display("FAIL parallel_strobe: got %0b want 1", photon_regwrite); end
        tick();
        core_regwrite = 1'b0;
        checks++; if (rf[8] !== 32'h0000_0808) begin errors++; $display("FAIL parallel_rf: got %h want 00000808", rf[8]); end
    endtask

    task automatic test_x0();
        req_valid = 1'b1; req_rd = 5'd0; req_data = 32'h0000_1234;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || photon_regwrite !== 1'b0) begin errors++; $display("FAIL x0_drop: got %0d/%0b want 0/0", count, photon_regwrite); end
        tick();
        checks++; if (photon_regwrite !== 1'b0 || rf[0] !== 32'h0) begin errors++; $display("FAIL x0_never: got %0b/%h want 0/0", photon_regwrite, rf[0]); end
    endtask

    task automatic test_pending();
        core_regwrite = 1'b1; core_rd = 5'd3; mem_hold = 1'b0;
        chk_rs1 = 5'd9; chk_rs2 = 5'd0;
        req_valid = 1'b1; req_rd = 5'd3; req_data = 32'h0000_0003;
        tick();
        req_rd = 5'd9; req_data = 32'h0000_0009;
        #1;
        checks++; if (pending_rs1 !== 1'b0) begin errors++; $display("FAIL pend_incoming: got %0b want 0", pending_rs1); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (pending_rs1 !== 1'b1 || pending_rs2 !== 1'b0) begin errors++; $display("FAIL pend_queued: got %0b%0b want 10", pending_rs1, pending_rs2); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pend_count: got %0d want 2", count); end
        core_regwrite = 1'b0;
        #1;
        checks++; if (photon_regwrite !== 1'b1 || addr_corereg_photon !== 5'd3) begin errors++; $display("FAIL pend_pop3: got %0b/%0d want 1/3", photon_regwrite, addr_corereg_photon); end
        tick();
        checks++; if (addr_corereg_photon !== 5'd9 || pending_rs1 !== 1'b1) begin errors++; $display("FAIL pend_popping: got %0d/%0b want 9/1", addr_corereg_photon, pending_rs1); end
        tick();
        checks++; if (pending_rs1 !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL pend_cleared: got %0b/%0d want 0/0", pending_rs1, count); end
        checks++; if (rf[9] !== 32'h0000_0009) begin errors++; $display("FAIL pend_rf: got %h want 00000009", rf[9]); end
        chk_rs1 = 5'd0;
    endtask

    task automatic test_reset_mid_drain();
        core_regwrite = 1'b1; core_rd = 5'd20; mem_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_rd = 5'(20 + i); req_data = 32'h2020_0000 + 32'(i);
            tick();
        end
        req_valid = 1'b0; chk_rs1 = 5'd21;
        #1;
        checks++; if (count !== 3'd3 || pending_rs1 !== 1'b1) begin errors++; $display("FAIL mid_setup: got %0d/%0b want 3/1", count, pending_rs1); end
        core_regwrite = 1'b0; Rst = 1'b1;
        req_valid = 1'b1; req_rd = 5'd26; req_data = 32'h0000_2626;
        #1;
        checks++; if (count !== 3'd0 || photon_regwrite !== 1'b0 || req_ready !== 1'b1 || pending_rs1 !== 1'b0) begin
            errors++; $display("FAIL mid_in_reset: got %0d/%0b/%0b/%0b want 0/0/1/0", count, photon_regwrite, req_ready, pending_rs1);
        end
        tick();
        Rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || photon_regwrite !== 1'b0 || req_ready !== 1'b1 || pending_rs1 !== 1'b0) begin
            errors++; $display("FAIL mid_after_reset: got %0d/%0b/%0b/%0b want 0/0/1/0", count, photon_regwrite, req_ready, pending_rs1);
        end
        tick();
        checks++; if (rf[20] !== 32'h0 || rf[26] !== 32'h0) begin errors++; $display("FAIL mid_discard: got %h/%h want 0/0", rf[20], rf[26]); end
        req_valid = 1'b1; req_rd = 5'd25; req_data = 32'h5555_0025;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (photon_regwrite !== 1'b1 || addr_corereg_photon !== 5'd25) begin errors++; $display("FAIL mid_repush: got %0b/%0d want 1/25", photon_regwrite, addr_corereg_photon); end
        tick();
        checks++; if (rf[25] !== 32'h5555_0025) begin errors++; $display("FAIL mid_rf: got %h want 55550025", rf[25]); end
        chk_rs1 = 5'd0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full_blocked();
        test_collision();
        test_x0();
        test_pending();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
